reaction_ctrl: RTL and testbench

- Sequencer for one reaction-timer trial. Arms on a Start press and latches the free-running RandomValue from the random wait generator as a random wait. Lights the stimulus LED when the wait expires.
- Measures the time to the React press in milliseconds and reports false starts and timeouts.
- Sits between the RandomGen block, the push-button inputs and the display/result logic.

---
 rtl/reaction_ctrl_if.sv | 27 ++
 rtl/reaction_ctrl.sv | 157 +++++++++++++++
 tb/tb_reaction_ctrl.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/reaction_ctrl_if.sv
// Signal bundle between the reaction-trial sequencer and its surroundings:
// push buttons and random wait value in, stimulus light and trial result out.
interface reaction_ctrl_if #(
   parameter int unsigned RAND_W = 13,
   parameter int unsigned TIME_W = 14
);
   logic              Start;
   logic              React;
   logic [RAND_W-1:0] RandomValue;
   logic              Led;
   logic [TIME_W-1:0] ReactTime;
   logic              Valid;
   logic              FalseStart;
   logic              Timeout;
   logic              Busy;

   // Master drives buttons and the random value, slave is the sequencer.
   modport master (
      output Start, React, RandomValue,
      input  Led, ReactTime, Valid, FalseStart, Timeout, Busy
   );

   modport slave (
      input  Start, React, RandomValue,
      output Led, ReactTime, Valid, FalseStart, Timeout, Busy
   );
endinterface

// File: rtl/reaction_ctrl.sv
// Reaction-timer trial sequencer: random wait, stimulus light, millisecond
// reaction measurement with false-start and timeout reporting.
module reaction_ctrl #(
   parameter int unsigned TICKS_PER_MS = 1000,
   parameter int unsigned RAND_W       = 13,
   parameter int unsigned MIN_WAIT_MS  = 1000,
   parameter int unsigned TIME_W       = 14,
   parameter int unsigned MAX_REACT_MS = 9999
) (
   input logic            Clk,
   input logic            Rst,
   reaction_ctrl_if.slave bus
);

   localparam int unsigned       PRE_W     = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
   localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(TICKS_PER_MS - 1);
   localparam logic [TIME_W-1:0] MIN_WAIT  = TIME_W'(MIN_WAIT_MS);
   localparam logic [TIME_W-1:0] MAX_REACT = TIME_W'(MAX_REACT_MS);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_WAIT  = 3'd1;
   localparam logic [2:0] S_GO    = 3'd2;
   localparam logic [2:0] S_DONE  = 3'd3;
   localparam logic [2:0] S_FAULT = 3'd4;

   logic [2:0]        r_state,      w_state_d;
   logic              r_start_prev, r_react_prev;
   logic [PRE_W-1:0]  r_pre,        w_pre_d;
   logic [TIME_W-1:0] r_ms_cnt,     w_ms_cnt_d;
   logic [TIME_W-1:0] r_wait_ms,    w_wait_ms_d;
   logic              r_led,        w_led_d;
   logic [TIME_W-1:0] r_react_time, w_react_time_d;
   logic              r_valid,      w_valid_d;
   logic              r_false,      w_false_d;
   logic              r_timeout,    w_timeout_d;
   logic              r_busy,       w_busy_d;

   logic              w_start_edge;
   logic              w_react_edge;
   logic              w_tick;
   logic [TIME_W-1:0] w_ms_inc;

   assign w_start_edge = bus.Start & ~r_start_prev;
   assign w_react_edge = bus.React & ~r_react_prev;
   assign w_tick       = (r_pre == PRE_LAST);
   assign w_ms_inc     = r_ms_cnt + TIME_W'(1);

   // Next-state and registered-output logic for one trial.
   always_comb begin
      w_state_d      = r_state;
      w_pre_d        = r_pre;
      w_ms_cnt_d     = r_ms_cnt;
      w_wait_ms_d    = r_wait_ms;
      w_led_d        = r_led;
      w_react_time_d = r_react_time;
      w_valid_d      = r_valid;
      w_false_d      = r_false;
      w_timeout_d    = r_timeout;

      case (r_state)
         S_IDLE, S_DONE, S_FAULT: begin
            if (w_start_edge) begin
               w_state_d      = S_WAIT;
               w_wait_ms_d    = MIN_WAIT + TIME_W'(bus.RandomValue);
               w_ms_cnt_d     = '0;
               w_pre_d        = '0;
               w_valid_d      = 1'b0;
               w_false_d      = 1'b0;
               w_timeout_d    = 1'b0;
               w_react_time_d = '0;
            end
         end
         S_WAIT: begin
            w_pre_d = w_tick ? '0 : r_pre + PRE_W'(1);
            if (w_tick) w_ms_cnt_d = w_ms_inc;
            // A press before the light beats an expiring wait.
            if (w_react_edge) begin
               w_state_d      = S_FAULT;
               w_false_d      = 1'b1;
               w_led_d        = 1'b0;
               w_react_time_d = '0;
               w_pre_d        = '0;
            end else if (w_tick && (w_ms_inc == r_wait_ms)) begin
               w_state_d  = S_GO;
               w_led_d    = 1'b1;
               w_ms_cnt_d = '0;
               w_pre_d    = '0;
            end
         end
         S_GO: begin
            w_pre_d = w_tick ? '0 : r_pre + PRE_W'(1);
            if (w_tick) w_ms_cnt_d = w_ms_inc;
            // Reported time is completed milliseconds; a press wins over timeout.
            if (w_react_edge) begin
               w_state_d      = S_DONE;
               w_react_time_d = r_ms_cnt;
               w_valid_d      = 1'b1;
               w_led_d        = 1'b0;
               w_pre_d        = '0;
            end else if (w_tick && (w_ms_inc == MAX_REACT)) begin
               w_state_d      = S_DONE;
               w_react_time_d = MAX_REACT;
               w_timeout_d    = 1'b1;
               w_valid_d      = 1'b0;
               w_led_d        = 1'b0;
               w_pre_d        = '0;
            end
         end
         default: begin
            w_state_d = S_IDLE;
            w_led_d   = 1'b0;
         end
      endcase

      w_busy_d = (w_state_d == S_WAIT) || (w_state_d == S_GO);
   end

   // State, counters, button history and outputs; history resets high so a
   // button held through reset is not taken as a press.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         r_state      <= S_IDLE;
         r_start_prev <= 1'b1;
         r_react_prev <= 1'b1;
         r_pre        <= '0;
         r_ms_cnt     <= '0;
         r_wait_ms    <= '0;
         r_led        <= 1'b0;
         r_react_time <= '0;
         r_valid      <= 1'b0;
         r_false      <= 1'b0;
         r_timeout    <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         r_state      <= w_state_d;
         r_start_prev <= bus.Start;
         r_react_prev <= bus.React;
         r_pre        <= w_pre_d;
         r_ms_cnt     <= w_ms_cnt_d;
         r_wait_ms    <= w_wait_ms_d;
         r_led        <= w_led_d;
         r_react_time <= w_react_time_d;
         r_valid      <= w_valid_d;
         r_false      <= w_false_d;
         r_timeout    <= w_timeout_d;
         r_busy       <= w_busy_d;
      end
   end

   assign bus.Led        = r_led;
   assign bus.ReactTime  = r_react_time;
   assign bus.Valid      = r_valid;
   assign bus.FalseStart = r_false;
   assign bus.Timeout    = r_timeout;
   assign bus.Busy       = r_busy;

endmodule

// File: tb/tb_reaction_ctrl.sv
// Bench for reaction_ctrl: directed trials with literal expectations plus
// randomized button traffic checked every cycle against a timing model.
module tb_reaction_ctrl;

   localparam int unsigned T      = 4;
   localparam int unsigned MINW   = 2;
   localparam int unsigned MAXR   = 20;
   localparam int unsigned RAND_W = 13;
   localparam int unsigned TIME_W = 14;

   logic Clk = 1'b0;
   logic Rst = 1'b0;

   reaction_ctrl_if #(.RAND_W(RAND_W), .TIME_W(TIME_W)) bus ();

   reaction_ctrl #(
      .TICKS_PER_MS (T),
      .RAND_W       (RAND_W),
      .MIN_WAIT_MS  (MINW),
      .TIME_W       (TIME_W),
      .MAX_REACT_MS (MAXR)
   ) dut (
      .Clk (Clk),
      .Rst (Rst),
      .bus (bus)
   );

   always #5 Clk = ~Clk;

   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s at %0t: got %0d, required %0d", name, $time, act, exp);
      end
   endtask

   // Behavioural model: phase plus elapsed cycles since phase entry.
   // phase 0 idle, 1 wait, 2 go, 3 done, 4 fault
   int m_phase = 0;
   int m_c     = 0;
   int m_wait  = 0;
   int m_led   = 0;
   int m_rt    = 0;
   int m_valid = 0;
   int m_fs    = 0;
   int m_to    = 0;
   int m_busy  = 0;
   int m_ps    = 1;
   int m_pr    = 1;

   always @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         m_phase = 0; m_c = 0; m_wait = 0; m_led = 0; m_rt = 0;
         m_valid = 0; m_fs = 0; m_to = 0; m_busy = 0; m_ps = 1; m_pr = 1;
      end else begin
         int se, re;
         se   = (bus.Start && !m_ps) ? 1 : 0;
         re   = (bus.React && !m_pr) ? 1 : 0;
         m_ps = bus.Start ? 1 : 0;
         m_pr = bus.React ? 1 : 0;
         case (m_phase)
            1: begin
               m_c++;
               if (re != 0) begin
                  m_phase = 4; m_fs = 1; m_rt = 0; m_led = 0;
               end else if (m_c == m_wait * int'(T)) begin
                  m_phase = 2; m_c = 0; m_led = 1;
               end
            end
            2: begin
               m_c++;
               if (re != 0) begin
                  m_phase = 3; m_rt = (m_c - 1) / int'(T); m_valid = 1; m_led = 0;
               end else if (m_c == int'(MAXR * T)) begin
                  m_phase = 3; m_rt = int'(MAXR); m_to = 1; m_valid = 0; m_led = 0;
               end
            end
            default: begin
               if (se != 0) begin
                  m_phase = 1; m_c = 0; m_wait = int'(MINW) + int'(bus.RandomValue);
                  m_valid = 0; m_fs = 0; m_to = 0; m_rt = 0;
               end
            end
         endcase
         m_busy = (m_phase == 1 || m_phase == 2) ? 1 : 0;
      end
   end

   // Every-cycle comparison against the model while out of reset.
   always @(negedge Clk) begin
      if (Rst) begin
         chk("model_led",   int'(bus.Led),        m_led);
         chk("model_rt",    int'(bus.ReactTime),  m_rt);
         chk("model_valid", int'(bus.Valid),      m_valid);
         chk("model_fs",    int'(bus.FalseStart), m_fs);
         chk("model_to",    int'(bus.Timeout),    m_to);
         chk("model_busy",  int'(bus.Busy),       m_busy);
      end
   end

   // Counts falling edges until Led is seen high, bounded.
   task automatic wait_led(output int n);
      n = 0;
      while (!bus.Led && n < 2000) begin
         @(negedge Clk);
         n++;
      end
   endtask

   task automatic press_start(input int rv);
      bus.Start       = 1'b0;
      bus.RandomValue = RAND_W'(rv);
      @(negedge Clk);
      bus.Start = 1'b1;
      @(negedge Clk);
      bus.Start = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got running, required finished");
      $fatal(1);
   end

   initial begin
      int n;
      int seen;

      // Buttons held through reset and after release: no trial starts.
      bus.Start = 1'b1; bus.React = 1'b1; bus.RandomValue = '0;
      repeat (3) @(negedge Clk);
      Rst = 1'b1;
      repeat (6) @(negedge Clk);
      chk("rst_led",   int'(bus.Led),        0);
      chk("rst_valid", int'(bus.Valid),      0);
      chk("rst_fs",    int'(bus.FalseStart), 0);
      chk("rst_to",    int'(bus.Timeout),    0);
      chk("rst_busy",  int'(bus.Busy),       0);
      bus.Start = 1'b0; bus.React = 1'b0;
      @(negedge Clk);

      // Normal trial: wait 5 ms -> 20 cycles; press 29 cycles into GO -> 7 ms.
      press_start(3);
      chk("norm_busy", int'(bus.Busy), 1);
      wait_led(n);
      chk("norm_led_delay", n, 20);
      repeat (28) @(negedge Clk);
      bus.React = 1'b1;
      @(negedge Clk);
      bus.React = 1'b0;
      chk("norm_rt",    int'(bus.ReactTime), 7);
      chk("norm_valid", int'(bus.Valid),     1);
      chk("norm_led",   int'(bus.Led),       0);
      chk("norm_busy0", int'(bus.Busy),      0);

      // False start 10 cycles into a long wait.
      press_start(100);
      repeat (9) @(negedge Clk);
      bus.React = 1'b1;
      @(negedge Clk);
      bus.React = 1'b0;
      chk("fs_flag",  int'(bus.FalseStart), 1);
      chk("fs_rt",    int'(bus.ReactTime),  0);
      chk("fs_valid", int'(bus.Valid),      0);
      seen = 0;
      repeat (50) begin
         @(negedge Clk);
         seen |= int'(bus.Led);
      end
      chk("fs_no_led", seen, 0);

      // Re-arm clears the false start; timeout trial with RandomValue 0.
      press_start(0);
      chk("fs_cleared", int'(bus.FalseStart), 0);
      wait_led(n);
      chk("to_led_delay", n, 8);
      n = 0;
      while (bus.Led && n < 2000) begin
         @(negedge Clk);
         n++;
      end
      chk("to_led_width", n, 80);
      chk("to_flag",  int'(bus.Timeout),   1);
      chk("to_rt",    int'(bus.ReactTime), 20);
      chk("to_valid", int'(bus.Valid),     0);

      // RandomValue and Start noise during WAIT and GO leave the trial alone.
      press_start(3);
      n = 0;
      while (!bus.Led && n < 2000) begin
         bus.RandomValue = RAND_W'($urandom_range(0, 8191));
         bus.Start       = $urandom_range(0, 1) == 1;
         @(negedge Clk);
         n++;
      end
      chk("ign_led_delay", n, 20);
      repeat (10) begin
         bus.RandomValue = RAND_W'($urandom_range(0, 8191));
         bus.Start       = $urandom_range(0, 1) == 1;
         @(negedge Clk);
      end
      chk("ign_go_led", int'(bus.Led), 1);
      bus.Start = 1'b0;
      bus.React = 1'b1;
      @(negedge Clk);
      bus.React = 1'b0;
      chk("ign_valid", int'(bus.Valid), 1);

      // Re-arm from DONE with 5 -> 7 ms wait; press on the timeout cycle.
      press_start(5);
      wait_led(n);
      chk("rearm_led_delay", n, 28);
      repeat (79) @(negedge Clk);
      bus.React = 1'b1;
      @(negedge Clk);
      bus.React = 1'b0;
      chk("tie_rt",    int'(bus.ReactTime), 19);
      chk("tie_valid", int'(bus.Valid),     1);
      chk("tie_to",    int'(bus.Timeout),   0);

      // Asynchronous reset while the light is on.
      press_start(0);
      wait_led(n);
      chk("arst_led_delay", n, 8);
      repeat (3) @(negedge Clk);
      #2 Rst = 1'b0;
      #1;
      chk("arst_led",   int'(bus.Led),        0);
      chk("arst_busy",  int'(bus.Busy),       0);
      chk("arst_valid", int'(bus.Valid),      0);
      chk("arst_fs",    int'(bus.FalseStart), 0);
      chk("arst_to",    int'(bus.Timeout),    0);
      chk("arst_rt",    int'(bus.ReactTime),  0);
      @(negedge Clk);
      Rst = 1'b1;
      repeat (5) @(negedge Clk);
      chk("arst_idle_busy", int'(bus.Busy), 0);
      chk("arst_idle_led",  int'(bus.Led),  0);

      // Random button traffic; second pass presses React rarely to reach timeouts.
      for (int pass = 0; pass < 2; pass++) begin
         for (int i = 0; i < 1500; i++) begin
            bus.RandomValue = RAND_W'($urandom_range(0, 15));
            bus.Start       = $urandom_range(0, 19) == 0;
            bus.React       = (pass == 0) ? ($urandom_range(0, 39) == 0)
                                          : ($urandom_range(0, 149) == 0);
            @(negedge Clk);
         end
      end
      bus.Start = 1'b0; bus.React = 1'b0;
      @(negedge Clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
